stim_vote_scheduler: RTL and testbench



---
 rtl/stim_vote_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_stim_vote_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_vote_scheduler.sv
// Epoch sequencer: collects line-length, power-spectrum and nonlinear-energy hits, 2-of-3 votes, debounces, drives stimulation.
// Latency: last feature strobe sampled at edge t -> vote_valid in cycle t+1; stimulation rises the cycle after the firing vote.
// No backpressure: strobes arriving while idle, stimulating or refractory are dropped; all outputs are registered.
module stim_vote_scheduler #(
    parameter int LL_WIDTH  = 25,
    parameter int MUL_WIDTH = 40,
    parameter int LL_TH     = 1000,
    parameter int PS_TH     = 1000,
    parameter int NE_TH     = 1000,
    parameter int CONSEC    = 2,
    parameter int TIMEOUT   = 4096,
    parameter int STIM_LEN  = 256,
    parameter int REFRACT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LL_WIDTH-1:0]  din_ll,
    input  logic [MUL_WIDTH-1:0] din_ps,
    input  logic [MUL_WIDTH-1:0] din_ne,
    input  logic                 data_ready_ll,
    input  logic                 data_ready_ps,
    input  logic                 data_ready_ne,
    output logic                 vote_valid,
    output logic                 vote,
    output logic                 epoch_timeout,
    output logic                 stimulation,
    output logic                 busy
);

    // Counter widths; the consecutive counter must be able to hold CONSEC itself.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int CW = $clog2(CONSEC + 1);
    localparam int SW = (STIM_LEN > 1) ? $clog2(STIM_LEN) : 1;
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    // The epoch ages one count per cycle after its first capture; when the
    // count is about to reach TIMEOUT-1 the epoch is abandoned.
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 2);
    localparam logic [CW-1:0] CONSEC_C   = CW'(CONSEC);
    localparam logic [SW-1:0] STIM_LAST  = SW'(STIM_LEN - 1);
    localparam logic [RW-1:0] REFR_LAST  = RW'(REFRACT - 1);

    // Thresholds sign-extended to the feature width for signed compares.
    localparam logic signed [LL_WIDTH-1:0]  LL_TH_S = LL_WIDTH'(LL_TH);
    localparam logic signed [MUL_WIDTH-1:0] PS_TH_S = MUL_WIDTH'(PS_TH);
    localparam logic signed [MUL_WIDTH-1:0] NE_TH_S = MUL_WIDTH'(NE_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_VOTE,
        S_STIM,
        S_REFRACT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    got, got_n;      // bit 2 = ll, bit 1 = ps, bit 0 = ne
    logic [2:0]    hit, hit_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [CW-1:0] consec, consec_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          vote_valid_n, vote_n, timeout_n, stim_n, busy_n;

    logic [2:0]    strb;
    logic [2:0]    now_hit;
    logic [2:0]    cap_got;
    logic [2:0]    cap_hit;
    logic          majority;

    assign strb     = {data_ready_ll, data_ready_ps, data_ready_ne};
    assign now_hit  = {$signed(din_ll) >= LL_TH_S,
                       $signed(din_ps) >= PS_TH_S,
                       $signed(din_ne) >= NE_TH_S};
    // Flags as they would be after this cycle's captures; a repeated strobe overwrites its hit.
    assign cap_got  = got | strb;
    assign cap_hit  = (hit & ~strb) | (now_hit & strb);
    assign majority = (cap_hit[2] & cap_hit[1]) | (cap_hit[2] & cap_hit[0]) | (cap_hit[1] & cap_hit[0]);

    // Next-state, epoch flags, counters and next output values.
    always_comb begin
        state_n      = state;
        got_n        = got;
        hit_n        = hit;
        tcnt_n       = tcnt;
        consec_n     = consec;
        scnt_n       = '0;
        rcnt_n       = '0;
        vote_valid_n = 1'b0;
        vote_n       = 1'b0;
        timeout_n    = 1'b0;
        if (!enable) begin
            state_n  = S_IDLE;
            got_n    = '0;
            hit_n    = '0;
            tcnt_n   = '0;
            consec_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_COLLECT;
                    got_n   = '0;
                    hit_n   = '0;
                    tcnt_n  = '0;
                end
                S_COLLECT: begin
                    if (&cap_got) begin
                        // Epoch complete, including captures made this very cycle.
                        state_n      = S_VOTE;
                        vote_valid_n = 1'b1;
                        vote_n       = majority;
                        if (!majority)
                            consec_n = '0;
                        else if (consec != CONSEC_C)
                            consec_n = consec + 1'b1;
                        got_n  = '0;
                        hit_n  = '0;
                        tcnt_n = '0;
                    end else if ((|got) && (tcnt == TO_LAST)) begin
                        // Stale epoch: discard it; any strobe this cycle opens a new one.
                        timeout_n = 1'b1;
                        consec_n  = '0;
                        got_n     = strb;
                        hit_n     = now_hit & strb;
                        tcnt_n    = (|strb) ? TW'(1) : '0;
                    end else begin
                        got_n  = cap_got;
                        hit_n  = cap_hit;
                        tcnt_n = (|cap_got) ? tcnt + 1'b1 : '0;
                    end
                end
                S_VOTE: begin
                    if (consec == CONSEC_C) begin
                        state_n  = S_STIM;
                        consec_n = '0;
                        got_n    = '0;
                        hit_n    = '0;
                        tcnt_n   = '0;
                    end else begin
                        // Flags were cleared on completion; strobes now belong to the next epoch.
                        state_n = S_COLLECT;
                        got_n   = strb;
                        hit_n   = now_hit & strb;
                        tcnt_n  = (|strb) ? TW'(1) : '0;
                    end
                end
                S_STIM: begin
                    got_n  = '0;
                    hit_n  = '0;
                    tcnt_n = '0;
                    if (scnt == STIM_LAST)
                        state_n = S_REFRACT;
                    else
                        scnt_n = scnt + 1'b1;
                end
                S_REFRACT: begin
                    got_n  = '0;
                    hit_n  = '0;
                    tcnt_n = '0;
                    if (rcnt == REFR_LAST)
                        state_n = S_COLLECT;
                    else
                        rcnt_n = rcnt + 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
        stim_n = (state_n == S_STIM);
        busy_n = (state_n == S_STIM) || (state_n == S_REFRACT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Epoch flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            got    <= '0;
            hit    <= '0;
            tcnt   <= '0;
            consec <= '0;
            scnt   <= '0;
            rcnt   <= '0;
        end else begin
            got    <= got_n;
            hit    <= hit_n;
            tcnt   <= tcnt_n;
            consec <= consec_n;
            scnt   <= scnt_n;
            rcnt   <= rcnt_n;
        end
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_valid    <= 1'b0;
            vote          <= 1'b0;
            epoch_timeout <= 1'b0;
            stimulation   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            vote_valid    <= vote_valid_n;
            vote          <= vote_n;
            epoch_timeout <= timeout_n;
            stimulation   <= stim_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_stim_vote_scheduler.sv
// Bench for stim_vote_scheduler: table vectors, directed multi-cycle sequences, randomized traffic.
// Every cycle is also compared against an epoch-level reference model held here.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_stim_vote_scheduler;

    localparam int LLW      = 25;
    localparam int MW       = 40;
    localparam int TH       = 1000;
    localparam int CONSEC   = 2;
    localparam int TIMEOUT  = 4096;
    localparam int STIM_LEN = 256;
    localparam int REFRACT  = 1024;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [LLW-1:0] din_ll;
    logic [MW-1:0]  din_ps;
    logic [MW-1:0]  din_ne;
    logic           data_ready_ll, data_ready_ps, data_ready_ne;
    logic           vote_valid, vote, epoch_timeout, stimulation, busy;
    logic [4:0]     outs;

    assign outs = {vote_valid, vote, epoch_timeout, stimulation, busy};

    stim_vote_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .din_ll        (din_ll),
        .din_ps        (din_ps),
        .din_ne        (din_ne),
        .data_ready_ll (data_ready_ll),
        .data_ready_ps (data_ready_ps),
        .data_ready_ne (data_ready_ne),
        .vote_valid    (vote_valid),
        .vote          (vote),
        .epoch_timeout (epoch_timeout),
        .stimulation   (stimulation),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: epoch flags, a cycle stamp for the epoch start, a streak
    // of positive votes and a single countdown covering stimulation + lockout.
    bit       m_on;
    bit       m_vote_cyc;
    bit [2:0] m_got, m_hit;
    int       m_first, m_streak, m_busy_left, m_cyc;
    bit [4:0] m_outs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_vote_cyc = 0; m_got = 0; m_hit = 0;
        m_first = 0; m_streak = 0; m_busy_left = 0; m_cyc = 0; m_outs = 0;
    endtask

    task automatic model_capture(input bit [2:0] s, input bit [2:0] h);
        if (s != 0 && m_got == 0) m_first = m_cyc;
        m_got = m_got | s;
        m_hit = (m_hit & ~s) | (h & s);
    endtask

    task automatic model_step(input bit en, input bit [2:0] s, input longint a, input longint b, input longint c);
        bit [2:0] h;
        bit       had, vv, vt, to;
        int       n;
        vv = 0; vt = 0; to = 0;
        h = {a >= TH, b >= TH, c >= TH};
        if (!en) begin
            m_on = 0; m_vote_cyc = 0; m_got = 0; m_hit = 0; m_streak = 0; m_busy_left = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (m_vote_cyc) begin
            m_vote_cyc = 0;
            if (m_streak >= CONSEC) begin
                m_streak = 0;
                m_busy_left = STIM_LEN + REFRACT;
            end else begin
                model_capture(s, h);
            end
        end else begin
            had = (m_got != 0);
            model_capture(s, h);
            if (m_got == 3'b111) begin
                n = $countones(m_hit);
                vv = 1;
                vt = (n >= 2);
                m_streak = vt ? ((m_streak + 1 > CONSEC) ? CONSEC : m_streak + 1) : 0;
                m_got = 0; m_hit = 0;
                m_vote_cyc = 1;
            end else if (had && (m_cyc - m_first == TIMEOUT - 2)) begin
                to = 1;
                m_streak = 0;
                m_got = 0; m_hit = 0;
                model_capture(s, h);
            end
        end
        m_outs = {vv, vt, to, m_busy_left > REFRACT, m_busy_left > 0};
        m_cyc++;
    endtask

    // One clock cycle of stimulus; the outputs seen afterwards belong to the next cycle.
    task automatic step(input bit en, input bit [2:0] s, input longint a, input longint b, input longint c);
        enable        = en;
        data_ready_ll = s[2];
        data_ready_ps = s[1];
        data_ready_ne = s[0];
        din_ll        = a[LLW-1:0];
        din_ps        = b[MW-1:0];
        din_ne        = c[MW-1:0];
        model_step(en, s, a, b, c);
        @(posedge clk);
        #1;
        check("model_outs", outs, m_outs);
        data_ready_ll = 1'b0;
        data_ready_ps = 1'b0;
        data_ready_ne = 1'b0;
    endtask

    task automatic idle_step();
        step(1'b1, 3'b000, 0, 0, 0);
    endtask

    // Staggered epoch: ll at t0, ps at t3, ne at t7.
    task automatic epoch(input longint a, input longint b, input longint c);
        step(1'b1, 3'b100, a, 0, 0);
        repeat (2) idle_step();
        step(1'b1, 3'b010, 0, b, 0);
        repeat (3) idle_step();
        step(1'b1, 3'b001, 0, 0, c);
    endtask

    typedef struct {
        bit       en;
        bit [2:0] strb;
        longint   vll;
        longint   vps;
        longint   vne;
        bit [4:0] exp;   // {vote_valid, vote, epoch_timeout, stimulation, busy}
    } vec_t;

    vec_t tv[$];

    initial begin
        int n_stim, n_busy, n_vv, k;
        bit [2:0] rs;

        rst = 1'b1; enable = 1'b0;
        din_ll = '0; din_ps = '0; din_ne = '0;
        data_ready_ll = 1'b0; data_ready_ps = 1'b0; data_ready_ne = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs, 5'b00000);
        rst = 1'b0;

        // Overwrite, VOTE-cycle capture feeding a staggered epoch, simultaneous strobes, streak clearing.
        tv.push_back('{1'b0, 3'b111, 2000, 2000, 2000, 5'b00000});
        tv.push_back('{1'b1, 3'b111, 2000, 2000, 2000, 5'b00000});
        tv.push_back('{1'b1, 3'b100, 2000, 0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b100, 10,   0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b010, 0,    2000, 0,    5'b00000});
        tv.push_back('{1'b1, 3'b001, 0,    0,    0,    5'b10000});
        tv.push_back('{1'b1, 3'b100, 1200, 0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b010, 0,    500,  0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b001, 0,    0,    1500, 5'b11000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b111, 999,  1000, -5,   5'b10000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b111, 2000, 2000, 2000, 5'b11000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        tv.push_back('{1'b1, 3'b000, 0,    0,    0,    5'b00000});
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].en, tv[i].strb, tv[i].vll, tv[i].vps, tv[i].vne);
            check($sformatf("vec%0d", i), outs, tv[i].exp);
        end

        // Two positive epochs fire; stimulation and lockout lengths.
        epoch(0, 0, 0);
        check("neg_epoch_vote", {vote_valid, vote}, 2'b10);
        idle_step();
        epoch(1200, 500, 1500);
        check("first_pos_vote", {vote_valid, vote}, 2'b11);
        idle_step();
        check("no_stim_after_one", stimulation, 1'b0);
        epoch(1200, 500, 1500);
        check("second_pos_vote", {vote_valid, vote}, 2'b11);
        idle_step();
        check("stim_rise", {stimulation, busy}, 2'b11);
        n_stim = 0; n_busy = 0; n_vv = 0;
        while (busy === 1'b1 && n_busy < 3000) begin
            n_busy++;
            if (stimulation === 1'b1) n_stim++;
            if (vote_valid === 1'b1) n_vv++;
            rs = 3'($urandom_range(0, 7));
            step(1'b1, rs, 2000, 2000, 2000);
        end
        check("stim_len", n_stim, STIM_LEN);
        check("busy_len", n_busy, STIM_LEN + REFRACT);
        check("no_vote_while_busy", n_vv, 0);

        // Timeout discards a partial epoch and clears the streak.
        step(1'b1, 3'b111, 2000, 2000, 2000);
        check("pos_before_timeout", {vote_valid, vote}, 2'b11);
        idle_step();
        step(1'b1, 3'b100, 1200, 0, 0);
        step(1'b1, 3'b010, 0, 2000, 0);
        k = 2;
        while (epoch_timeout !== 1'b1 && k < 6000) begin
            idle_step();
            k++;
        end
        check("timeout_latency", k, TIMEOUT - 1);
        idle_step();
        check("timeout_one_cycle", epoch_timeout, 1'b0);
        step(1'b1, 3'b001, 0, 0, 2000);
        check("fresh_flags", vote_valid, 1'b0);
        step(1'b1, 3'b110, 2000, 2000, 0);
        check("vote_after_timeout", {vote_valid, vote}, 2'b11);
        idle_step();
        check("consec_cleared_by_timeout", stimulation, 1'b0);

        // Abort at cycle 100 of stimulation.
        step(1'b1, 3'b111, 2000, 2000, 2000);
        idle_step();
        check("stim_start", stimulation, 1'b1);
        repeat (99) idle_step();
        check("stim_before_abort", stimulation, 1'b1);
        step(1'b0, 3'b000, 0, 0, 0);
        check("abort_outs", {stimulation, busy}, 2'b00);
        step(1'b0, 3'b111, 2000, 2000, 2000);
        step(1'b1, 3'b111, 2000, 2000, 2000);
        check("idle_ignores_strobes", vote_valid, 1'b0);
        step(1'b1, 3'b111, 2000, 2000, 2000);
        check("collect_after_abort", {vote_valid, vote}, 2'b11);
        idle_step();

        // Asynchronous reset while vote_valid is high, with the streak at its firing value.
        step(1'b1, 3'b111, 2000, 2000, 2000);
        check("pre_reset_vote", {vote_valid, vote}, 2'b11);
        #2 rst = 1'b1;
        #1 check("async_reset", outs, 5'b00000);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        idle_step();
        step(1'b1, 3'b111, 2000, 2000, 2000);
        check("vote_after_reset", {vote_valid, vote}, 2'b11);
        idle_step();
        check("consec_cleared_by_reset", stimulation, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit     en;
            longint a, b, c;
            en = ($urandom_range(0, 299) != 0);
            rs[2] = ($urandom_range(0, 3) == 0);
            rs[1] = ($urandom_range(0, 3) == 0);
            rs[0] = ($urandom_range(0, 3) == 0);
            a = longint'($urandom_range(0, 1600)) - 400;
            b = longint'($urandom_range(0, 1600)) - 400;
            c = longint'($urandom_range(0, 1600)) - 400;
            step(en, rs, a, b, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
